// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: picks the highest-priority exception on an accepted EX
// instruction, waits for the data bus to drain, then issues one commit cycle and one kill cycle.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic        ex_bd,
    input  logic        ex_fetch_adel,
    input  logic        ex_ri,
    input  logic        ex_ov,
    input  logic        ex_syscall,
    input  logic        ex_break,
    input  logic        ex_eret,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [31:0] ex_mem_addr,
    input  logic [1:0]  ex_mem_size,
    input  logic        mem_busy,
    input  logic        int_req,
    input  logic [31:0] epc_in,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_badvaddr,
    output logic [31:0] exc_pc,
    output logic        exc_bd,
    output logic        eret_flush,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2,
        KILL   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic        eret_q, eret_d;

    logic        accept;
    logic        misaligned;
    logic        has_exc;
    logic [4:0]  cand_code;
    logic [31:0] cand_badv;

    assign accept = ex_valid && (state_q == IDLE);

    always_comb begin
        misaligned = 1'b0;
        if (ex_mem_size == 2'd1) misaligned = ex_mem_addr[0];
        else if (ex_mem_size == 2'd2) misaligned = (ex_mem_addr[1:0] != 2'b00);
    end

    // Priority chain, highest first; interrupts ride on the accepted instruction.
    always_comb begin
        has_exc   = 1'b1;
        cand_code = 5'd0;
        cand_badv = 32'd0;
        if (int_req) begin
            cand_code = 5'd0;
        end else if (ex_fetch_adel) begin
            cand_code = 5'd4;
            cand_badv = ex_pc;
        end else if (ex_ri) begin
            cand_code = 5'd10;
        end else if (ex_ov) begin
            cand_code = 5'd12;
        end else if (ex_syscall) begin
            cand_code = 5'd8;
        end else if (ex_break) begin
            cand_code = 5'd9;
        end else if (ex_mem_rd && misaligned) begin
            cand_code = 5'd4;
            cand_badv = ex_mem_addr;
        end else if (ex_mem_wr && misaligned) begin
            cand_code = 5'd5;
            cand_badv = ex_mem_addr;
        end else begin
            has_exc = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        badv_d  = badv_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        eret_d  = eret_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (has_exc || ex_eret)) begin
                    pc_d   = ex_pc;
                    bd_d   = ex_bd;
                    eret_d = ex_eret && !has_exc;
                    if (!has_exc) begin
                        code_d = 5'd0;
                        badv_d = 32'd0;
                    end else if (ex_eret) begin
                        // An eret that collides with any exception is reported as code 8.
                        code_d = 5'd8;
                        badv_d = 32'd0;
                    end else begin
                        code_d = cand_code;
                        badv_d = cand_badv;
                    end
                    state_d = mem_busy ? DRAIN : COMMIT;
                end
            end
            DRAIN:  if (!mem_busy) state_d = COMMIT;
            COMMIT: state_d = KILL;
            KILL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            code_q  <= 5'd0;
            badv_q  <= 32'd0;
            pc_q    <= 32'd0;
            bd_q    <= 1'b0;
            eret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            badv_q  <= badv_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            eret_q  <= eret_d;
        end
    end

    always_comb begin
        ex_ready       = (state_q == IDLE);
        exc_valid      = (state_q == COMMIT) && !eret_q;
        eret_flush     = (state_q == COMMIT) && eret_q;
        redirect_valid = (state_q == COMMIT);
        flush          = (state_q == COMMIT) || (state_q == KILL);
        redirect_pc    = 32'd0;
        if (state_q == COMMIT) redirect_pc = eret_q ? epc_in : EXC_VECTOR;
        exc_code       = code_q;
        exc_badvaddr   = badv_q;
        exc_pc         = pc_q;
        exc_bd         = bd_q;
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed and randomized checks of exc_ctrl against a timeline-level reference model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk, rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc;
    logic        ex_bd, ex_fetch_adel, ex_ri, ex_ov, ex_syscall, ex_break, ex_eret;
    logic        ex_mem_rd, ex_mem_wr;
    logic [31:0] ex_mem_addr;
    logic [1:0]  ex_mem_size;
    logic        mem_busy, int_req;
    logic [31:0] epc_in;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr, exc_pc;
    logic        exc_bd, eret_flush, flush, redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    exc_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_bd(ex_bd), .ex_fetch_adel(ex_fetch_adel), .ex_ri(ex_ri),
        .ex_ov(ex_ov), .ex_syscall(ex_syscall), .ex_break(ex_break), .ex_eret(ex_eret),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_addr(ex_mem_addr),
        .ex_mem_size(ex_mem_size), .mem_busy(mem_busy), .int_req(int_req), .epc_in(epc_in),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .eret_flush(eret_flush), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        bd, adel, ri, ov, sys, brk, eret, rd, wr, irq;
        logic [31:0] addr;
        logic [1:0]  size;
    } instr_t;

    typedef struct {
        logic        ev;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] badv;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input instr_t t);
        exp_t e;
        logic mis;
        mis = (t.size == 2'd1 && t.addr[0]) || (t.size == 2'd2 && t.addr[1:0] != 2'b00);
        e.ev = 1'b1; e.eret = 1'b0; e.code = 5'd0; e.badv = 32'd0;
        if (t.irq)              e.code = 5'd0;
        else if (t.adel)        begin e.code = 5'd4; e.badv = t.pc; end
        else if (t.ri)          e.code = 5'd10;
        else if (t.ov)          e.code = 5'd12;
        else if (t.sys)         e.code = 5'd8;
        else if (t.brk)         e.code = 5'd9;
        else if (t.rd && mis)   begin e.code = 5'd4; e.badv = t.addr; end
        else if (t.wr && mis)   begin e.code = 5'd5; e.badv = t.addr; end
        else begin
            e.ev = t.eret;
            e.eret = t.eret;
        end
        if (e.ev && !e.eret && t.eret) begin e.code = 5'd8; e.badv = 32'd0; end
        return e;
    endfunction

    function automatic instr_t blank();
        instr_t t;
        t.pc = 32'd0; t.bd = 0; t.adel = 0; t.ri = 0; t.ov = 0; t.sys = 0; t.brk = 0;
        t.eret = 0; t.rd = 0; t.wr = 0; t.irq = 0; t.addr = 32'd0; t.size = 2'd0;
        return t;
    endfunction

    task automatic drive(input instr_t t, input logic v);
        ex_valid = v; ex_pc = t.pc; ex_bd = t.bd; ex_fetch_adel = t.adel; ex_ri = t.ri;
        ex_ov = t.ov; ex_syscall = t.sys; ex_break = t.brk; ex_eret = t.eret;
        ex_mem_rd = t.rd; ex_mem_wr = t.wr; ex_mem_addr = t.addr; ex_mem_size = t.size;
        int_req = t.irq;
    endtask

    // One instruction from accept through drain, commit, kill and back to idle.
    task automatic run(input instr_t t, input int busy, input logic [31:0] epc);
        exp_t e;
        e = model(t);
        chk("ready_pre", ex_ready, 1);
        drive(t, 1'b1);
        mem_busy = (busy > 0);
        epc_in = epc;
        step();
        drive(blank(), 1'b0);
        int_req = $urandom_range(0, 1);  // must be ignored outside an accept
        if (!e.ev) begin
            mem_busy = 0;
            chk("noexc_valid", exc_valid, 0);
            chk("noexc_flush", flush, 0);
            chk("noexc_redir", redirect_valid, 0);
            chk("noexc_ready", ex_ready, 1);
            int_req = 0;
            return;
        end
        for (int k = 1; k <= busy; k++) begin
            chk("drain_ready", ex_ready, 0);
            chk("drain_flush", flush, 0);
            chk("drain_valid", exc_valid, 0);
            chk("drain_redir", redirect_valid, 0);
            mem_busy = (k < busy);
            step();
        end
        mem_busy = 0;
        chk("commit_flush", flush, 1);
        chk("commit_redir", redirect_valid, 1);
        chk("commit_ready", ex_ready, 0);
        chk("commit_valid", exc_valid, !e.eret);
        chk("commit_eret", eret_flush, e.eret);
        chk("commit_rpc", redirect_pc, e.eret ? epc : VEC);
        if (!e.eret) begin
            chk("commit_code", exc_code, e.code);
            chk("commit_badv", exc_badvaddr, e.badv);
            chk("commit_pc", exc_pc, t.pc);
            chk("commit_bd", exc_bd, t.bd);
        end
        step();
        chk("kill_flush", flush, 1);
        chk("kill_ready", ex_ready, 0);
        chk("kill_valid", exc_valid, 0);
        chk("kill_eret", eret_flush, 0);
        chk("kill_redir", redirect_valid, 0);
        if (!e.eret) chk("kill_code_hold", exc_code, e.code);
        step();
        int_req = 0;
        chk("post_ready", ex_ready, 1);
        chk("post_flush", flush, 0);
    endtask

    initial begin
        instr_t t;
        drive(blank(), 1'b0);
        mem_busy = 0; epc_in = 0;
        rst = 0;
        #2;
        chk("rst_ready", ex_ready, 1);
        chk("rst_valid", exc_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_code", exc_code, 0);
        chk("rst_rpc", redirect_pc, 0);
        step(); step();
        rst = 1;
        step();

        // Misaligned word load
        t = blank(); t.pc = 32'h8000_0100; t.rd = 1; t.addr = 32'h1000_0002; t.size = 2'd2;
        run(t, 0, 32'h0);
        // Eret, bus idle
        t = blank(); t.eret = 1; t.pc = 32'h8000_0040;
        run(t, 0, 32'h8000_0200);
        // RI beats OV; interrupt beats both
        t = blank(); t.ri = 1; t.ov = 1; t.bd = 1; t.pc = 32'h8000_0300;
        run(t, 0, 32'h0);
        t.irq = 1;
        run(t, 0, 32'h0);
        // Misaligned half store with three busy cycles
        t = blank(); t.wr = 1; t.size = 2'd1; t.addr = 32'h0000_0003; t.pc = 32'h8000_0400;
        run(t, 3, 32'h0);
        // Byte access never misaligned; eret colliding with overflow
        t = blank(); t.rd = 1; t.size = 2'd0; t.addr = 32'h0000_0003;
        run(t, 0, 32'h0);
        t = blank(); t.eret = 1; t.ov = 1; t.pc = 32'h8000_0500;
        run(t, 1, 32'h1234_5678);

        // Reset during DRAIN abandons the capture
        t = blank(); t.wr = 1; t.size = 2'd2; t.addr = 32'h0000_0001; t.pc = 32'h8000_0600;
        drive(t, 1'b1);
        mem_busy = 1;
        step();
        drive(blank(), 1'b0);
        chk("drain_before_rst", ex_ready, 0);
        rst = 0;
        #1;
        chk("rstd_ready", ex_ready, 1);
        chk("rstd_valid", exc_valid, 0);
        chk("rstd_flush", flush, 0);
        chk("rstd_redir", redirect_valid, 0);
        chk("rstd_eret", eret_flush, 0);
        chk("rstd_code", exc_code, 0);
        chk("rstd_badv", exc_badvaddr, 0);
        chk("rstd_pc", exc_pc, 0);
        chk("rstd_rpc", redirect_pc, 0);
        #2;
        rst = 1;
        mem_busy = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postrst_valid", exc_valid, 0);
            chk("postrst_flush", flush, 0);
            chk("postrst_ready", ex_ready, 1);
        end

        // Clean traffic: nothing may fire
        for (int i = 0; i < 100; i++) begin
            t = blank();
            t.pc = $urandom & 32'hFFFF_FFFC;
            t.bd = $urandom_range(0, 1);
            t.rd = $urandom_range(0, 1);
            t.wr = !t.rd && ($urandom_range(0, 1) == 1);
            t.size = 2'($urandom_range(0, 2));
            t.addr = $urandom;
            if (t.size == 2'd1) t.addr[0] = 1'b0;
            if (t.size == 2'd2) t.addr[1:0] = 2'b00;
            run(t, $urandom_range(0, 1), 32'h0);
        end

        // Mixed random traffic
        for (int i = 0; i < 80; i++) begin
            t = blank();
            t.pc = $urandom;
            t.bd = $urandom_range(0, 1);
            t.irq = ($urandom_range(0, 7) == 0);
            t.adel = ($urandom_range(0, 7) == 0);
            t.ri = ($urandom_range(0, 7) == 0);
            t.ov = ($urandom_range(0, 7) == 0);
            t.sys = ($urandom_range(0, 7) == 0);
            t.brk = ($urandom_range(0, 7) == 0);
            t.eret = ($urandom_range(0, 5) == 0);
            t.rd = $urandom_range(0, 1);
            t.wr = $urandom_range(0, 1);
            t.size = 2'($urandom_range(0, 2));
            t.addr = $urandom;
            run(t, $urandom_range(0, 3), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, exception entry address.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports ex_valid (input, 1, EX instruction present) and ex_ready (output, 1, EX instruction accepted this edge).
REQ-005 SHALL have inputs ex_pc (32), ex_bd (1, delay slot), ex_fetch_adel (1), ex_ri (1), ex_ov (1), ex_syscall (1), ex_break (1), ex_eret (1).
REQ-006 SHALL have inputs ex_mem_rd (1), ex_mem_wr (1), ex_mem_addr (32) and ex_mem_size (2: 0=byte, 1=half, 2=word).
REQ-007 SHALL have inputs mem_busy (1, outstanding data-bus transaction), int_req (1, CP0 Interrupt) and epc_in (32, CP0 EPC_out).
REQ-008 SHALL have outputs exc_valid (1), exc_code (5), exc_badvaddr (32), exc_pc (32) and exc_bd (1), all feeding the CP0 exception inputs.
REQ-009 SHALL have outputs eret_flush (1), flush (1, kill IF/ID/EX), redirect_valid (1) and redirect_pc (32).

Function
REQ-010 SHALL implement states IDLE, DRAIN, COMMIT and KILL.
REQ-011 SHALL drive ex_ready=1 only in IDLE.
REQ-012 SHALL decode a candidate on each accepted instruction (ex_valid && ex_ready) using this priority, highest first:
- int_req -> code 0
- ex_fetch_adel -> code 4, badvaddr = ex_pc
- ex_ri -> code 10
- ex_ov -> code 12
- ex_syscall -> code 8
- ex_break -> code 9
- misaligned load -> code 4, badvaddr = ex_mem_addr
- misaligned store -> code 5, badvaddr = ex_mem_addr
REQ-013 SHALL define misaligned as: size 1 with addr[0]=1, or size 2 with addr[1:0]!=0; size 0 is never misaligned.
REQ-014 SHALL set badvaddr to 0 for codes other than 4 and 5.
REQ-015 SHALL, on accepting an instruction with an exception or ex_eret, capture code, badvaddr, pc, bd and an eret flag, then move to DRAIN if mem_busy=1 at that edge, else to COMMIT.
REQ-016 SHALL treat eret as an exception with code 8 when any exception condition coexists with it; an exception always wins over eret.
REQ-017 SHALL, on an accepted instruction without exception or eret, stay in IDLE with all outputs 0.
REQ-018 SHALL remain in DRAIN while mem_busy=1 and go to COMMIT on the first edge with mem_busy=0.
REQ-019 SHALL, for exactly one cycle in COMMIT, assert flush=1 and redirect_valid=1, plus either:
- exception: exc_valid=1, exc_code/badvaddr/pc/bd = captured values, redirect_pc = EXC_VECTOR
- eret: eret_flush=1, exc_valid=0, redirect_pc = epc_in sampled combinationally during COMMIT
REQ-020 SHALL go COMMIT -> KILL -> IDLE unconditionally; KILL holds flush=1 and ex_ready=0 so the wrong-path EX instruction is discarded.
REQ-021 SHALL hold exc_valid, eret_flush and redirect_valid at 0 outside COMMIT.
REQ-022 SHALL hold exc_code, exc_badvaddr, exc_pc and exc_bd stable from capture until the next capture.
REQ-023 SHALL ignore int_req in every state other than IDLE, and in IDLE when ex_valid=0; interrupts attach only to an accepted instruction.
REQ-024 SHALL never assert exc_valid and eret_flush in the same cycle.
REQ-025 SHALL make latency from accept to COMMIT 1 cycle when mem_busy=0, and 1 + (mem_busy-high cycles) otherwise.

Reset
REQ-026 SHALL, on rst=0 in any state, immediately enter IDLE and drive:
- all 1-bit outputs 0 except ex_ready=1
- exc_code=0, exc_badvaddr=0, exc_pc=0, redirect_pc=0
REQ-027 SHALL abandon any capture held in DRAIN or COMMIT on reset; after release, COMMIT is not entered without a new accept.

Verification
REQ-028 SHALL cover: ex_pc=32'h8000_0100, ex_mem_rd=1, addr=32'h1000_0002, size=2 -> next cycle exc_valid=1, code=4, badvaddr=32'h1000_0002, redirect_pc=32'hBFC00380, then one KILL cycle.
REQ-029 SHALL cover: ex_eret=1, epc_in=32'h8000_0200, mem_busy=0 -> next cycle eret_flush=1, flush=1, redirect_pc=32'h8000_0200, exc_valid=0.
REQ-030 SHALL cover: ex_ri=1 and ex_ov=1 and ex_bd=1 together -> code=10, exc_bd=1; a second run with int_req=1 added -> code=0.
REQ-031 SHALL cover: store size=1, addr=32'h0000_0003, mem_busy high 3 cycles -> DRAIN for 3 cycles, ex_ready=0, then a single-cycle commit with code=5.
REQ-032 SHALL cover: rst pulsed low during DRAIN -> outputs at reset values immediately, and no exc_valid after release.
REQ-033 SHALL cover: 100 random non-exception instructions with int_req=0 -> exc_valid, flush and redirect_valid never asserted, and ex_ready=1 throughout.
